stream_fifo: RTL and testbench

- Parameterised first-word-fall-through FIFO with valid/ready handshake on both sides.
- Sits between a producing stage and a consuming stage of configurable data width. It decouples their timing and absorbs up to DEPTH words of backpressure.
- Also reports occupancy and a programmable almost-full flag so the upstream stage can throttle early.

---
 rtl/stream_fifo.sv | 93 +++++++++
 tb/tb_stream_fifo.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides, occupancy count,
// programmable almost-full flag and a sticky error for words offered during flush.
module stream_fifo #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         push_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);

  // Explicit wrap compare so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? PW'(0) : p + PW'(1);
  endfunction

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_err_r;
  logic             push_s;
  logic             pop_s;
  logic             wr_en_s;
  logic [CW-1:0]    count_nxt_s;

  assign in_ready    = (count_r != FULL_C);
  assign out_valid   = (count_r != CW'(0));
  assign almost_full = (count_r >= AF_C);
  assign out_data    = mem_r[rd_ptr_r];
  assign count       = count_r;
  assign push_err    = push_err_r;

  // Handshake decode and next occupancy.
  always_comb begin
    push_s      = in_valid & in_ready;
    pop_s       = out_valid & out_ready;
    wr_en_s     = push_s & rst_n & ~flush;
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and sticky-error state; reset beats flush beats traffic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r   <= PW'(0);
      rd_ptr_r   <= PW'(0);
      count_r    <= CW'(0);
      push_err_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r   <= PW'(0);
      rd_ptr_r   <= PW'(0);
      count_r    <= CW'(0);
      push_err_r <= push_err_r | in_valid;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_nxt_s;
    end
  end

  // Storage is intentionally left unreset; only accepted words are written.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Randomised and directed checks of stream_fifo (DEPTH=4 and DEPTH=3 instances)
// against a queue-based reference model.
module tb_stream_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       flush_a, in_valid_a, out_ready_a, in_ready_a, out_valid_a;
  logic       almost_full_a, push_err_a;
  logic [3:0] in_data_a, out_data_a;
  logic [2:0] count_a;

  logic       flush_b, in_valid_b, out_ready_b, in_ready_b, out_valid_b;
  logic       almost_full_b, push_err_b;
  logic [3:0] in_data_b, out_data_b;
  logic [1:0] count_b;

  stream_fifo #(.WIDTH(4), .DEPTH(4), .AF_LEVEL(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .count(count_a), .almost_full(almost_full_a), .push_err(push_err_a)
  );

  stream_fifo #(.WIDTH(4), .DEPTH(3), .AF_LEVEL(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .count(count_b), .almost_full(almost_full_b), .push_err(push_err_b)
  );

  logic [3:0] qa[$];
  logic [3:0] qb[$];
  logic       perr_a, perr_b;
  int         nvec, nerr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the current inputs, then compare.
  task automatic step();
    bit pa, acca, pb, accb;
    pa   = out_ready_a && (qa.size() > 0);
    acca = in_valid_a && (qa.size() < 4);
    pb   = out_ready_b && (qb.size() > 0);
    accb = in_valid_b && (qb.size() < 3);
    if (!rst_n) begin
      qa.delete(); qb.delete();
      perr_a = 1'b0; perr_b = 1'b0;
    end else begin
      if (flush_a) begin
        if (in_valid_a) perr_a = 1'b1;
        qa.delete();
      end else begin
        if (pa) void'(qa.pop_front());
        if (acca) qa.push_back(in_data_a);
      end
      if (flush_b) begin
        if (in_valid_b) perr_b = 1'b1;
        qb.delete();
      end else begin
        if (pb) void'(qb.pop_front());
        if (accb) qb.push_back(in_data_b);
      end
    end
    @(posedge clk);
    #1;
    chk("a_in_ready", in_ready_a, qa.size() != 4);
    chk("a_out_valid", out_valid_a, qa.size() != 0);
    chk("a_count", count_a, 32'(qa.size()));
    chk("a_almost_full", almost_full_a, qa.size() >= 3);
    chk("a_push_err", push_err_a, perr_a);
    if (qa.size() > 0) chk("a_out_data", out_data_a, qa[0]);
    chk("b_in_ready", in_ready_b, qb.size() != 3);
    chk("b_out_valid", out_valid_b, qb.size() != 0);
    chk("b_count", count_b, 32'(qb.size()));
    chk("b_almost_full", almost_full_b, qb.size() >= 2);
    chk("b_push_err", push_err_b, perr_b);
    if (qb.size() > 0) chk("b_out_data", out_data_b, qb[0]);
  endtask

  initial begin
    nvec = 0; nerr = 0;
    perr_a = 1'b0; perr_b = 1'b0;
    rst_n = 1'b0;
    flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0; in_data_a = 4'h0;
    flush_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0; in_data_b = 4'h0;
    #1;
    step(); step();
    rst_n = 1'b1;
    step();

    // Fill to full, then offer a fifth word that must be held off.
    for (int i = 1; i <= 4; i++) begin
      in_valid_a = 1'b1; in_data_a = 4'(i);
      step();
    end
    in_data_a = 4'h5;
    step();
    chk("a_full_in_ready", in_ready_a, 1'b0);

    // Pop from full while 0x5 is still offered, then drain.
    out_ready_a = 1'b1;
    step();
    chk("a_pop_from_full_count", count_a, 32'd3);
    step();
    chk("a_push_pop_count", count_a, 32'd3);
    in_valid_a = 1'b0;
    repeat (4) step();

    // DEPTH=3 streaming with continuous push and pop exercises pointer wrap.
    out_ready_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid_b = 1'b1; in_data_b = 4'(i);
      step();
      chk("b_count_le1", count_b <= 2'd1, 1'b1);
    end
    in_valid_b = 1'b0;
    repeat (2) step();

    // Flush while a word is offered sets the sticky error.
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; in_data_a = 4'h7; step();
    in_data_a = 4'h8; step();
    flush_a = 1'b1; in_data_a = 4'h9; step();
    flush_a = 1'b0; in_data_a = 4'hA; step();
    in_valid_a = 1'b0; step();
    chk("a_after_flush_data", out_data_a, 32'hA);

    // Reset mid-stream with in_valid held through release.
    in_valid_a = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data_a = 4'(i); step();
    end
    rst_n = 1'b0; in_data_a = 4'h6; step();
    rst_n = 1'b1; step();
    in_valid_a = 1'b0; out_ready_a = 1'b1; step();
    step();

    // Randomised traffic on both instances.
    for (int n = 0; n < 600; n++) begin
      rst_n       = ($urandom_range(0, 149) != 0);
      flush_a     = ($urandom_range(0, 39) == 0);
      flush_b     = ($urandom_range(0, 39) == 0);
      in_valid_a  = $urandom_range(0, 2) != 0;
      in_valid_b  = $urandom_range(0, 1) != 0;
      out_ready_a = $urandom_range(0, 1) != 0;
      out_ready_b = $urandom_range(0, 2) != 0;
      in_data_a   = 4'($urandom);
      in_data_b   = 4'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
